// File: rtl/rob_multi_wb.sv
// Reorder buffer with NUM_WB writeback channels, in-order single retire and mispredict flush.
// Optional define ROB_WB_BYPASS_EN forwards same-cycle writebacks to the operand lookups.
module rob_multi_wb #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int NUM_WB = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,

    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [31:0]              disp_pc,
    input  logic [4:0]               disp_rd,
    input  logic                     disp_is_ls,
    input  logic                     disp_is_br,
    input  logic                     disp_pred_taken,
    output logic [IDX_W-1:0]         disp_tag,

    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]  wb_tag,
    input  logic [NUM_WB*32-1:0]     wb_res,
    input  logic [NUM_WB-1:0]        wb_taken,
    input  logic [NUM_WB*32-1:0]     wb_target,

    input  logic [IDX_W-1:0]         q1_tag,
    input  logic [IDX_W-1:0]         q2_tag,
    output logic                     q1_ready,
    output logic                     q2_ready,
    output logic [31:0]              q1_val,
    output logic [31:0]              q2_val,

    output logic                     ls_head_valid,
    output logic [IDX_W-1:0]         ls_head_tag,

    output logic                     commit_valid,
    output logic [4:0]               commit_rd,
    output logic [31:0]              commit_res,
    output logic [IDX_W-1:0]         commit_tag,

    output logic                     bp_update_valid,
    output logic [31:0]              bp_update_pc,
    output logic                     bp_update_taken,

    output logic                     flush,
    output logic [31:0]              flush_pc,

    output logic [IDX_W:0]           count
);

    localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit so all DEPTH slots are usable.
    logic [IDX_W:0]    head_ptr;
    logic [IDX_W:0]    tail_ptr;
    logic [IDX_W-1:0]  head_idx;
    logic [IDX_W-1:0]  tail_idx;

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  ent_ready;
    logic [4:0]        ent_rd     [DEPTH];
    logic [31:0]       ent_pc     [DEPTH];
    logic [31:0]       ent_res    [DEPTH];
    logic [31:0]       ent_target [DEPTH];
    logic [DEPTH-1:0]  ent_is_ls;
    logic [DEPTH-1:0]  ent_is_br;
    logic [DEPTH-1:0]  ent_pred;
    logic [DEPTH-1:0]  ent_taken;

    logic              empty;
    logic              full;
    logic              do_alloc;
    logic              do_commit;
    logic              mispredict;

    logic [IDX_W-1:0]  wb_tag_ch [NUM_WB];
    logic [NUM_WB-1:0] wb_hit;

    assign head_idx = head_ptr[IDX_W-1:0];
    assign tail_idx = tail_ptr[IDX_W-1:0];
    assign empty    = (head_ptr == tail_ptr);
    assign full     = (head_idx == tail_idx) && (head_ptr[IDX_W] != tail_ptr[IDX_W]);

    // Nothing but the clearing happens while a flush is being taken.
    assign do_alloc   = disp_valid && !full && !flush;
    assign do_commit  = !empty && ent_ready[head_idx] && !flush;
    assign mispredict = ent_is_br[head_idx] && (ent_pred[head_idx] != ent_taken[head_idx]);

    assign disp_ready    = !full;
    assign disp_tag      = tail_idx;
    assign count         = tail_ptr - head_ptr;
    assign ls_head_valid = !empty && ent_is_ls[head_idx] && !ent_ready[head_idx];
    assign ls_head_tag   = head_idx;

    // NOTE: every variable assigned in always_comb gets a value on every path, or a latch is inferred.
    always_comb begin
        for (int i = 0; i < NUM_WB; i++) begin
            wb_tag_ch[i] = wb_tag[i*IDX_W +: IDX_W];
            wb_hit[i]    = wb_valid[i] && busy[wb_tag_ch[i]] && !flush;
        end
    end

    // Returns {ready, value}; the value reads as zero until the entry holds a result.
    function automatic logic [32:0] lookup(input logic [IDX_W-1:0] tag);
        logic        hit;
        logic [31:0] val;
        hit = busy[tag] && ent_ready[tag];
        val = hit ? ent_res[tag] : 32'd0;
`ifdef ROB_WB_BYPASS_EN
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_valid[i] && busy[tag] && (wb_tag_ch[i] == tag)) begin
                hit = 1'b1;
                val = wb_res[i*32 +: 32];
            end
        end
`endif
        return {hit, val};
    endfunction

    always_comb begin
        {q1_ready, q1_val} = lookup(q1_tag);
        {q2_ready, q2_val} = lookup(q2_tag);
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments in the block win.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr        <= '0;
            tail_ptr        <= '0;
            busy            <= '0;
            ent_ready       <= '0;
            commit_valid    <= 1'b0;
            commit_rd       <= '0;
            commit_res      <= '0;
            commit_tag      <= '0;
            bp_update_valid <= 1'b0;
            bp_update_pc    <= '0;
            bp_update_taken <= 1'b0;
            flush           <= 1'b0;
            flush_pc        <= '0;
        end else if (rdy) begin
            if (flush) begin
                head_ptr        <= '0;
                tail_ptr        <= '0;
                busy            <= '0;
                ent_ready       <= '0;
                commit_valid    <= 1'b0;
                bp_update_valid <= 1'b0;
                flush           <= 1'b0;
            end else begin
                for (int i = 0; i < NUM_WB; i++) begin
                    if (wb_hit[i]) begin
                        ent_ready[wb_tag_ch[i]] <= 1'b1;
                    end
                end

                commit_valid    <= do_commit;
                bp_update_valid <= do_commit && ent_is_br[head_idx];
                flush           <= do_commit && mispredict;

                if (do_commit) begin
                    busy[head_idx]      <= 1'b0;
                    ent_ready[head_idx] <= 1'b0;
                    head_ptr            <= head_ptr + PTR_ONE;
                    commit_rd           <= ent_rd[head_idx];
                    commit_res          <= ent_res[head_idx];
                    commit_tag          <= head_idx;
                    bp_update_pc        <= ent_pc[head_idx];
                    bp_update_taken     <= ent_taken[head_idx];
                    flush_pc            <= ent_target[head_idx];
                end

                if (do_alloc) begin
                    busy[tail_idx]      <= 1'b1;
                    ent_ready[tail_idx] <= 1'b0;
                    tail_ptr            <= tail_ptr + PTR_ONE;
                end
            end
        end
    end

    // NOTE: payload storage has no reset; busy/ready qualify every read of it.
    always_ff @(posedge clk) begin
        if (rdy && !rst) begin
            if (do_alloc) begin
                ent_rd[tail_idx]    <= disp_rd;
                ent_pc[tail_idx]    <= disp_pc;
                ent_is_ls[tail_idx] <= disp_is_ls;
                ent_is_br[tail_idx] <= disp_is_br;
                ent_pred[tail_idx]  <= disp_pred_taken;
            end
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_hit[i]) begin
                    ent_res[wb_tag_ch[i]]    <= wb_res[i*32 +: 32];
                    ent_taken[wb_tag_ch[i]]  <= wb_taken[i];
                    ent_target[wb_tag_ch[i]] <= wb_target[i*32 +: 32];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_wb.sv
// Self-checking bench for rob_multi_wb (DEPTH=4): directed vector table, mispredict and
// bypass sequences, then random traffic against a queue-based reference model.
module tb_rob_multi_wb;

    localparam int DEPTH  = 4;
    localparam int IDX_W  = 2;
    localparam int NUM_WB = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    rdy;
    logic                    disp_valid;
    logic                    disp_ready;
    logic [31:0]             disp_pc;
    logic [4:0]              disp_rd;
    logic                    disp_is_ls;
    logic                    disp_is_br;
    logic                    disp_pred_taken;
    logic [IDX_W-1:0]        disp_tag;
    logic [NUM_WB-1:0]       wb_valid;
    logic [NUM_WB*IDX_W-1:0] wb_tag;
    logic [NUM_WB*32-1:0]    wb_res;
    logic [NUM_WB-1:0]       wb_taken;
    logic [NUM_WB*32-1:0]    wb_target;
    logic [IDX_W-1:0]        q1_tag;
    logic [IDX_W-1:0]        q2_tag;
    logic                    q1_ready;
    logic                    q2_ready;
    logic [31:0]             q1_val;
    logic [31:0]             q2_val;
    logic                    ls_head_valid;
    logic [IDX_W-1:0]        ls_head_tag;
    logic                    commit_valid;
    logic [4:0]              commit_rd;
    logic [31:0]             commit_res;
    logic [IDX_W-1:0]        commit_tag;
    logic                    bp_update_valid;
    logic [31:0]             bp_update_pc;
    logic                    bp_update_taken;
    logic                    flush;
    logic [31:0]             flush_pc;
    logic [IDX_W:0]          count;

    always #5 clk = ~clk;

    rob_multi_wb #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pc(disp_pc),
        .disp_rd(disp_rd), .disp_is_ls(disp_is_ls), .disp_is_br(disp_is_br),
        .disp_pred_taken(disp_pred_taken), .disp_tag(disp_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_res(wb_res),
        .wb_taken(wb_taken), .wb_target(wb_target),
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_val(q1_val), .q2_val(q2_val),
        .ls_head_valid(ls_head_valid), .ls_head_tag(ls_head_tag),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_res(commit_res),
        .commit_tag(commit_tag),
        .bp_update_valid(bp_update_valid), .bp_update_pc(bp_update_pc),
        .bp_update_taken(bp_update_taken),
        .flush(flush), .flush_pc(flush_pc), .count(count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight instructions in program order.
    typedef struct {
        logic [IDX_W-1:0] tag;
        logic [4:0]       rd;
        logic [31:0]      pc;
        bit               is_ls;
        bit               is_br;
        bit               pred;
        bit               ready;
        bit               taken;
        logic [31:0]      res;
        logic [31:0]      target;
    } ent_t;

    ent_t        mq[$];
    int          m_tail;
    bit          m_cv, m_bpv, m_bpt, m_flush;
    logic [4:0]  m_crd;
    logic [31:0] m_cres, m_bppc, m_fpc;
    logic [IDX_W-1:0] m_ctag;

    task automatic model_step();
        bit   do_c;
        int   pre_size;
        ent_t h;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_tail = 0;
            m_cv = 0; m_bpv = 0; m_bpt = 0; m_flush = 0;
            m_crd = '0; m_cres = '0; m_bppc = '0; m_fpc = '0; m_ctag = '0;
        end else if (rdy) begin
            if (m_flush) begin
                mq.delete();
                m_tail = 0;
                m_cv = 0; m_bpv = 0; m_flush = 0;
            end else begin
                pre_size = mq.size();
                do_c = (pre_size > 0) && mq[0].ready;
                if (do_c) h = mq[0];
                for (int ch = 0; ch < NUM_WB; ch++) begin
                    if (wb_valid[ch]) begin
                        foreach (mq[j]) begin
                            if (mq[j].tag == wb_tag[ch*IDX_W +: IDX_W]) begin
                                mq[j].ready  = 1;
                                mq[j].res    = wb_res[ch*32 +: 32];
                                mq[j].taken  = wb_taken[ch];
                                mq[j].target = wb_target[ch*32 +: 32];
                            end
                        end
                    end
                end
                m_cv    = do_c;
                m_bpv   = do_c && h.is_br;
                m_flush = do_c && h.is_br && (h.pred != h.taken);
                if (do_c) begin
                    m_crd = h.rd; m_cres = h.res; m_ctag = h.tag;
                    m_bppc = h.pc; m_bpt = h.taken; m_fpc = h.target;
                    void'(mq.pop_front());
                end
                if (disp_valid && pre_size < DEPTH) begin
                    e.tag = IDX_W'(m_tail % DEPTH);
                    e.rd = disp_rd; e.pc = disp_pc;
                    e.is_ls = disp_is_ls; e.is_br = disp_is_br; e.pred = disp_pred_taken;
                    e.ready = 0; e.taken = 0; e.res = '0; e.target = '0;
                    mq.push_back(e);
                    m_tail++;
                end
            end
        end
    endtask

    task automatic m_lookup(input logic [IDX_W-1:0] t, output bit r, output logic [31:0] v);
        bit in_flight;
        r = 0; v = '0; in_flight = 0;
        foreach (mq[j]) begin
            if (mq[j].tag == t) begin
                in_flight = 1;
                if (mq[j].ready) begin r = 1; v = mq[j].res; end
            end
        end
`ifdef ROB_WB_BYPASS_EN
        for (int ch = 0; ch < NUM_WB; ch++) begin
            if (in_flight && wb_valid[ch] && wb_tag[ch*IDX_W +: IDX_W] == t) begin
                r = 1; v = wb_res[ch*32 +: 32];
            end
        end
`endif
    endtask

    task automatic compare_all();
        bit          r;
        logic [31:0] v;
        check("disp_ready", disp_ready, mq.size() < DEPTH);
        check("disp_tag", disp_tag, m_tail % DEPTH);
        check("count", count, mq.size());
        check("ls_head_valid", ls_head_valid, mq.size() > 0 && mq[0].is_ls && !mq[0].ready);
        check("ls_head_tag", ls_head_tag, mq.size() > 0 ? mq[0].tag : IDX_W'(m_tail % DEPTH));
        check("commit_valid", commit_valid, m_cv);
        if (m_cv) begin
            check("commit_rd", commit_rd, m_crd);
            check("commit_res", commit_res, m_cres);
            check("commit_tag", commit_tag, m_ctag);
        end
        check("bp_update_valid", bp_update_valid, m_bpv);
        if (m_bpv) begin
            check("bp_update_pc", bp_update_pc, m_bppc);
            check("bp_update_taken", bp_update_taken, m_bpt);
        end
        check("flush", flush, m_flush);
        if (m_flush) check("flush_pc", flush_pc, m_fpc);
        m_lookup(q1_tag, r, v);
        check("q1_ready", q1_ready, r);
        check("q1_val", q1_val, v);
        m_lookup(q2_tag, r, v);
        check("q2_ready", q2_ready, r);
        check("q2_val", q2_val, v);
    endtask

    task automatic idle_inputs();
        disp_valid = 0; disp_pc = '0; disp_rd = '0; disp_is_ls = 0; disp_is_br = 0;
        disp_pred_taken = 0; wb_valid = '0; wb_tag = '0; wb_res = '0; wb_taken = '0;
        wb_target = '0; q1_tag = '0; q2_tag = '0;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic step_chk();
        @(negedge clk);
        compare_all();
        advance();
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy = 1;
        rst = 1;
        advance();
        advance();
        rst = 0;
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_disp_ready", disp_ready, 1);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_flush", flush, 0);
        check("rst_zero_outs", {disp_tag, q1_ready, q1_val, q2_ready, q2_val, ls_head_valid,
                                ls_head_tag, commit_rd, commit_res, commit_tag},   '0);
        check("rst_zero_bp", {bp_update_valid, bp_update_pc, bp_update_taken, flush_pc}, '0);
        advance();
    endtask

    typedef struct {
        bit          dv;
        logic [4:0]  rd;
        logic [1:0]  wbv;
        logic [1:0]  t0;
        logic [31:0] r0;
        logic [1:0]  t1;
        logic [31:0] r1;
        logic [1:0]  qt;
        logic [2:0]  e_cnt;
        logic [1:0]  e_dtag;
        bit          e_drdy;
        bit          e_cv;
        logic [1:0]  e_ctag;
        logic [4:0]  e_crd;
        logic [31:0] e_cres;
        bit          qchk;
        bit          e_qrdy;
        logic [31:0] e_qval;
    } vec_t;

    function automatic vec_t mk(bit dv, logic [4:0] rd, logic [1:0] wbv, logic [1:0] t0,
                                logic [31:0] r0, logic [1:0] t1, logic [31:0] r1, logic [1:0] qt,
                                logic [2:0] e_cnt, logic [1:0] e_dtag, bit e_drdy, bit e_cv,
                                logic [1:0] e_ctag, logic [4:0] e_crd, logic [31:0] e_cres,
                                bit qchk, bit e_qrdy, logic [31:0] e_qval);
        vec_t v;
        v.dv = dv; v.rd = rd; v.wbv = wbv; v.t0 = t0; v.r0 = r0; v.t1 = t1; v.r1 = r1;
        v.qt = qt; v.e_cnt = e_cnt; v.e_dtag = e_dtag; v.e_drdy = e_drdy; v.e_cv = e_cv;
        v.e_ctag = e_ctag; v.e_crd = e_crd; v.e_cres = e_cres; v.qchk = qchk;
        v.e_qrdy = e_qrdy; v.e_qval = e_qval;
        return v;
    endfunction

    task automatic rand_inputs();
        logic [IDX_W-1:0] t;
        rst = ($urandom_range(255) == 0);
        rdy = ($urandom_range(7) != 0);
        disp_valid = $urandom_range(1);
        disp_pc = $urandom;
        disp_rd = 5'($urandom);
        disp_is_ls = ($urandom_range(3) == 0);
        disp_is_br = ($urandom_range(3) == 0);
        disp_pred_taken = $urandom_range(1);
        for (int ch = 0; ch < NUM_WB; ch++) begin
            if (mq.size() > 0 && $urandom_range(3) != 0) t = mq[$urandom_range(mq.size() - 1)].tag;
            else t = IDX_W'($urandom_range(DEPTH - 1));
            wb_valid[ch] = $urandom_range(1);
            wb_tag[ch*IDX_W +: IDX_W] = t;
            wb_res[ch*32 +: 32] = $urandom;
            wb_taken[ch] = $urandom_range(1);
            wb_target[ch*32 +: 32] = $urandom;
        end
        q1_tag = IDX_W'($urandom_range(DEPTH - 1));
        q2_tag = IDX_W'($urandom_range(DEPTH - 1));
    endtask

    initial begin
        vec_t vecs[22];
        vecs[0]  = mk(1, 1, 0, 0, 0,     0, 0,     0, 0, 0, 1, 0, 0, 0, 0,     0, 0, 0);
        vecs[1]  = mk(1, 2, 0, 0, 0,     0, 0,     0, 1, 1, 1, 0, 0, 0, 0,     0, 0, 0);
        vecs[2]  = mk(1, 3, 0, 0, 0,     0, 0,     0, 2, 2, 1, 0, 0, 0, 0,     0, 0, 0);
        vecs[3]  = mk(1, 4, 0, 0, 0,     0, 0,     0, 3, 3, 1, 0, 0, 0, 0,     0, 0, 0);
        vecs[4]  = mk(1, 9, 0, 0, 0,     0, 0,     0, 4, 0, 0, 0, 0, 0, 0,     0, 0, 0);
        vecs[5]  = mk(0, 0, 1, 2, 'hC,   0, 0,     0, 4, 0, 0, 0, 0, 0, 0,     0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 1, 'hB,   0, 0,     0, 4, 0, 0, 0, 0, 0, 0,     0, 0, 0);
        vecs[7]  = mk(0, 0, 1, 0, 'hA,   0, 0,     0, 4, 0, 0, 0, 0, 0, 0,     0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0,     0, 0,     0, 4, 0, 0, 0, 0, 0, 0,     0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0,     0, 0,     0, 3, 0, 1, 1, 0, 1, 'hA,   0, 0, 0);
        vecs[10] = mk(1, 5, 0, 0, 0,     0, 0,     0, 2, 0, 1, 1, 1, 2, 'hB,   0, 0, 0);
        vecs[11] = mk(1, 6, 0, 0, 0,     0, 0,     0, 2, 1, 1, 1, 2, 3, 'hC,   0, 0, 0);
        vecs[12] = mk(1, 7, 0, 0, 0,     0, 0,     0, 3, 2, 1, 0, 0, 0, 0,     0, 0, 0);
        vecs[13] = mk(0, 0, 3, 3, 'h33,  0, 'h44,  0, 4, 3, 0, 0, 0, 0, 0,     0, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0,     0, 0,     0, 4, 3, 0, 0, 0, 0, 0,     0, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0,     0, 0,     0, 3, 3, 1, 1, 3, 4, 'h33,  0, 0, 0);
        vecs[16] = mk(0, 0, 3, 1, 'h11,  1, 'h22,  0, 2, 3, 1, 1, 0, 5, 'h44,  0, 0, 0);
        vecs[17] = mk(0, 0, 0, 0, 0,     0, 0,     0, 2, 3, 1, 0, 0, 0, 0,     0, 0, 0);
        vecs[18] = mk(0, 0, 1, 3, 'h99,  0, 0,     3, 1, 3, 1, 1, 1, 6, 'h22,  1, 0, 0);
        vecs[19] = mk(0, 0, 1, 2, 'h5,   0, 0,     3, 1, 3, 1, 0, 0, 0, 0,     1, 0, 0);
        vecs[20] = mk(0, 0, 0, 0, 0,     0, 0,     2, 1, 3, 1, 0, 0, 0, 0,     1, 1, 'h5);
        vecs[21] = mk(0, 0, 0, 0, 0,     0, 0,     0, 0, 3, 1, 1, 2, 7, 'h5,   0, 0, 0);

        do_reset();

        // Fill, overflow, out-of-order completion, wrap reuse, dual channel, dropped writeback.
        for (int k = 0; k < 22; k++) begin
            idle_inputs();
            disp_valid = vecs[k].dv;
            disp_rd    = vecs[k].rd;
            disp_pc    = 32'h100 + 32'(k * 4);
            wb_valid   = vecs[k].wbv;
            wb_tag     = {vecs[k].t1, vecs[k].t0};
            wb_res     = {vecs[k].r1, vecs[k].r0};
            q1_tag     = vecs[k].qt;
            @(negedge clk);
            check($sformatf("vec%0d_count", k), count, vecs[k].e_cnt);
            check($sformatf("vec%0d_disp_tag", k), disp_tag, vecs[k].e_dtag);
            check($sformatf("vec%0d_disp_ready", k), disp_ready, vecs[k].e_drdy);
            check($sformatf("vec%0d_commit_valid", k), commit_valid, vecs[k].e_cv);
            if (vecs[k].e_cv) begin
                check($sformatf("vec%0d_commit_tag", k), commit_tag, vecs[k].e_ctag);
                check($sformatf("vec%0d_commit_rd", k), commit_rd, vecs[k].e_crd);
                check($sformatf("vec%0d_commit_res", k), commit_res, vecs[k].e_cres);
            end
            if (vecs[k].qchk) begin
                check($sformatf("vec%0d_q1_ready", k), q1_ready, vecs[k].e_qrdy);
                check($sformatf("vec%0d_q1_val", k), q1_val, vecs[k].e_qval);
            end
            compare_all();
            advance();
        end

        // Mispredicted branch at the head with two younger entries in flight.
        do_reset();
        idle_inputs();
        disp_valid = 1; disp_pc = 32'h200; disp_rd = 0; disp_is_br = 1; disp_pred_taken = 0;
        step_chk();
        disp_pc = 32'h204; disp_rd = 1; disp_is_br = 0;
        step_chk();
        disp_pc = 32'h208; disp_rd = 2;
        step_chk();
        idle_inputs();
        wb_valid = 2'b01; wb_tag = '0; wb_taken = 2'b01; wb_target = {32'h0, 32'h1000};
        step_chk();
        idle_inputs();
        step_chk();
        disp_valid = 1; wb_valid = 2'b11; wb_tag = {2'd2, 2'd1};
        @(negedge clk);
        check("mp_commit_valid", commit_valid, 1);
        check("mp_commit_tag", commit_tag, 0);
        check("mp_flush", flush, 1);
        check("mp_flush_pc", flush_pc, 32'h1000);
        check("mp_bp_valid", bp_update_valid, 1);
        check("mp_bp_taken", bp_update_taken, 1);
        check("mp_bp_pc", bp_update_pc, 32'h200);
        compare_all();
        advance();
        idle_inputs();
        @(negedge clk);
        check("mp_flush_done", flush, 0);
        check("mp_cv_done", commit_valid, 0);
        check("mp_bp_done", bp_update_valid, 0);
        check("mp_count_zero", count, 0);
        compare_all();
        advance();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mp_no_young_commit", commit_valid, 0);
            advance();
        end

        // Same-cycle lookup of a writeback.
        do_reset();
        idle_inputs();
        disp_valid = 1;
        for (int k = 0; k < 4; k++) step_chk();
        idle_inputs();
        wb_valid = 2'b01; wb_tag = {2'd0, 2'd3}; wb_res = {32'h0, 32'h55};
        q1_tag = 3; q2_tag = 3;
        @(negedge clk);
`ifdef ROB_WB_BYPASS_EN
        check("byp_same_ready", q1_ready, 1);
        check("byp_same_val", q1_val, 32'h55);
`else
        check("byp_same_ready", q1_ready, 0);
`endif
        compare_all();
        advance();
        idle_inputs();
        q1_tag = 3;
        @(negedge clk);
        check("byp_next_ready", q1_ready, 1);
        check("byp_next_val", q1_val, 32'h55);
        compare_all();
        advance();

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rand_inputs();
            step_chk();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
